// File: rtl/branch_redirect_ctrl.sv
// Front-end recovery sequencer: detects a mispredict on a branch resolved in ID, issues a
// registered PC redirect with IF/ID and ID/EX flushes, and keeps saturating perf counters.
module branch_redirect_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              br_id,
    input  logic              pred_taken_id,
    input  logic              br_taken_id,
    input  logic [ADDR_W-1:0] target_id,
    input  logic [ADDR_W-1:0] fallthru_id,
    input  logic              clr_cnt,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              busy,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StRefill
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic accept;
    logic mispredict;

    // Branches are only resolved in IDLE with the pipeline moving; anything else is
    // wrong-path or a bubble.
    assign accept     = (state_q == StIdle) && br_id && !stall_mem;
    assign mispredict = pred_taken_id ^ br_taken_id;

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StIdle: begin
                if (accept && mispredict) begin
                    state_d       = StRedirect;
                    redirect_pc_d = br_taken_id ? target_id : fallthru_id;
                end
            end
            StRedirect: begin
                if (!stall_mem) state_d = StRefill;
            end
            StRefill: begin
                if (!stall_mem) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (clr_cnt) begin
            br_cnt_d   = '0;
            miss_cnt_d = '0;
        end else if (accept) begin
            if (br_cnt_q != CntMax) br_cnt_d = br_cnt_q + 1'b1;
            if (mispredict && (miss_cnt_q != CntMax)) miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    // Strobes decode from state only, so no input reaches an output combinationally.
    always_comb begin
        redirect   = (state_q == StRedirect);
        flush_ifid = (state_q == StRedirect);
        flush_idex = (state_q == StRedirect);
        busy       = (state_q != StIdle);
    end

    assign redirect_pc = redirect_pc_q;
    assign br_cnt      = br_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboarded bench for branch_redirect_ctrl: each driven cycle queues the outputs expected
// after the next edge; a monitor pops and compares them. A CNT_W=2 copy checks saturation.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall_mem, br_id, pred_taken_id, br_taken_id, clr_cnt;
    logic [31:0] target_id, fallthru_id;

    logic        redirect, flush_ifid, flush_idex, busy;
    logic [31:0] redirect_pc;
    logic [15:0] br_cnt, miss_cnt;

    logic        s_redirect, s_flush_ifid, s_flush_idex, s_busy;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_br_cnt, s_miss_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  s;
        logic [31:0] pc;
        logic [15:0] br;
        logic [15:0] miss;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(16)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_mem     (stall_mem),
        .br_id         (br_id),
        .pred_taken_id (pred_taken_id),
        .br_taken_id   (br_taken_id),
        .target_id     (target_id),
        .fallthru_id   (fallthru_id),
        .clr_cnt       (clr_cnt),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .busy          (busy),
        .br_cnt        (br_cnt),
        .miss_cnt      (miss_cnt)
    );

    branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(2)) u_dut_sat (
        .clk           (clk),
        .rst           (rst),
        .stall_mem     (stall_mem),
        .br_id         (br_id),
        .pred_taken_id (pred_taken_id),
        .br_taken_id   (br_taken_id),
        .target_id     (target_id),
        .fallthru_id   (fallthru_id),
        .clr_cnt       (clr_cnt),
        .redirect      (s_redirect),
        .redirect_pc   (s_redirect_pc),
        .flush_ifid    (s_flush_ifid),
        .flush_idex    (s_flush_idex),
        .busy          (s_busy),
        .br_cnt        (s_br_cnt),
        .miss_cnt      (s_miss_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // s: 0 = idle, 1 = redirecting, 2 = refilling (expected state after the coming edge).
    task automatic step(input logic br, input logic pred, input logic tk, input logic stall,
                        input logic clr, input logic rs, input logic [31:0] tgt,
                        input logic [31:0] ft, input logic [1:0] s, input logic [31:0] pc,
                        input logic [15:0] b, input logic [15:0] m);
        @(negedge clk);
        br_id         = br;
        pred_taken_id = pred;
        br_taken_id   = tk;
        stall_mem     = stall;
        clr_cnt       = clr;
        rst           = rs;
        target_id     = tgt;
        fallthru_id   = ft;
        exp_q.push_back('{s, pc, b, m});
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("redirect",    {63'd0, redirect},   {63'd0, e.s == 2'd1});
                check_val("flush_ifid",  {63'd0, flush_ifid}, {63'd0, e.s == 2'd1});
                check_val("flush_idex",  {63'd0, flush_idex}, {63'd0, e.s == 2'd1});
                check_val("busy",        {63'd0, busy},       {63'd0, e.s != 2'd0});
                check_val("redirect_pc", {32'd0, redirect_pc}, {32'd0, e.pc});
                check_val("br_cnt",      {48'd0, br_cnt},     {48'd0, e.br});
                check_val("miss_cnt",    {48'd0, miss_cnt},   {48'd0, e.miss});
            end
        end
    end

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check_val("drain_timeout", {32'd0, exp_q.size()}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; stall_mem = 1'b0; br_id = 1'b0; pred_taken_id = 1'b0;
        br_taken_id = 1'b0; clr_cnt = 1'b0; target_id = '0; fallthru_id = '0;

        // Reset
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0);

        // Correct prediction, not taken
        step(1, 0, 0, 0, 0, 0, 32'h10, 32'h14, 0, 32'h0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0);

        // Mispredict taken: one redirect cycle, one refill cycle
        step(1, 0, 1, 0, 0, 0, 32'h100, 32'h44, 1, 32'h100, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h100, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 2, 1);

        // Mispredict not-taken, redirect held through 3 stalled cycles; br_id ignored meanwhile
        step(1, 1, 0, 0, 0, 0, 32'h200, 32'h48, 1, 32'h48, 3, 2);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 0, 32'h300, 32'h4c, 1, 32'h48, 3, 2);
        step(1, 0, 1, 0, 0, 0, 32'h300, 32'h4c, 2, 32'h48, 3, 2);
        step(1, 0, 1, 0, 0, 0, 32'h300, 32'h4c, 0, 32'h48, 3, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h48, 3, 2);

        // Branch held in ID under stall: resolved once, when the stall drops
        step(1, 0, 0, 1, 0, 0, 32'h60, 32'h64, 0, 32'h48, 3, 2);
        step(1, 0, 0, 1, 0, 0, 32'h60, 32'h64, 0, 32'h48, 3, 2);
        step(1, 0, 0, 0, 0, 0, 32'h60, 32'h64, 0, 32'h48, 4, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h48, 4, 2);

        // Reset mid-REDIRECT drops everything; a following correct branch counts from zero
        step(1, 0, 1, 0, 0, 0, 32'h200, 32'h80, 1, 32'h200, 5, 3);
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 32'h400, 32'h84, 0, 32'h0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0);

        // Saturation: clear, then 5 mispredicts
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 1, 0, 0, 0, 32'h1000 + 32'(i * 4), 32'h8, 1, 32'h1000 + 32'(i * 4),
                 16'(i), 16'(i));
            step(0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h1000 + 32'(i * 4), 16'(i), 16'(i));
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000 + 32'(i * 4), 16'(i), 16'(i));
        end
        drain();
        check_val("sat_br_cnt",   {62'd0, s_br_cnt},   64'd3);
        check_val("sat_miss_cnt", {62'd0, s_miss_cnt}, 64'd3);

        // Clear wins over a same-cycle accept; the FSM still redirects
        step(1, 1, 0, 0, 1, 0, 32'h2000, 32'h2004, 1, 32'h2004, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h2004, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2004, 0, 0);
        drain();
        check_val("sat_br_clr",   {62'd0, s_br_cnt},   64'd0);
        check_val("sat_miss_clr", {62'd0, s_miss_cnt}, 64'd0);
        check_val("sat_redirect_pc", {32'd0, s_redirect_pc}, 64'h2004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
